// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// The optional clock monitor is enabled by defining PLL_RST_SEQ_CLKMON_EN.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        CORE_RUN,
        ALL_RUN
    } state_t;

    localparam int unsigned DEF_LOCK_STABLE_CYC = 1024;
    localparam int unsigned DEF_STAGE_GAP_CYC   = 256;
    localparam int unsigned DEF_MON_WINDOW      = 50000;
    localparam int unsigned DEF_MON_EXP         = 3500;
    localparam int unsigned DEF_MON_TOL         = 8;

    localparam int unsigned CNT8_W  = 8;
    localparam int unsigned CNT16_W = 16;

endpackage

// File: rtl/pll_rst_seq_bit_sync.sv
// N-stage single-bit synchronizer, asynchronously cleared to 0.
// STAGES must be at least 2.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// Staged core/CPU reset release after stable PLL lock, with lock-loss counting.
// Define PLL_RST_SEQ_CLKMON_EN to add the slow_clk frequency monitor.
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int unsigned STAGE_GAP_CYC   = DEF_STAGE_GAP_CYC,
    parameter int unsigned MON_WINDOW      = DEF_MON_WINDOW,
    parameter int unsigned MON_EXP         = DEF_MON_EXP,
    parameter int unsigned MON_TOL         = DEF_MON_TOL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              slow_clk,
    output logic              rst_core_n,
    output logic              rst_cpu_n,
    output logic              ready,
    output logic [CNT8_W-1:0] lock_loss_cnt,
    output logic              clk_fault
);

    localparam logic [CNT16_W-1:0] STAB_LAST = CNT16_W'(LOCK_STABLE_CYC);
    localparam logic [CNT16_W-1:0] GAP_LAST  = CNT16_W'(STAGE_GAP_CYC - 1);

    state_t               state, state_nxt;
    logic [CNT16_W-1:0]   stab_cnt, stab_nxt;
    logic [CNT16_W-1:0]   gap_cnt, gap_nxt;
    logic                 lock_s;
    logic                 fault;
    logic                 drop;

    bit_sync #(.STAGES(2)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

`ifdef PLL_RST_SEQ_CLKMON_EN
    localparam logic [CNT16_W-1:0] WIN_LAST = CNT16_W'(MON_WINDOW - 1);
    localparam logic [CNT16_W-1:0] EDGE_LO  = CNT16_W'(MON_EXP - MON_TOL);
    localparam logic [CNT16_W-1:0] EDGE_HI  = CNT16_W'(MON_EXP + MON_TOL);

    logic               slow_s, slow_d, slow_rise;
    logic [CNT16_W-1:0] win_cnt, edge_cnt, edge_tot;

    bit_sync #(.STAGES(3)) u_slow_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (slow_clk),
        .q     (slow_s)
    );

    assign slow_rise = slow_s & ~slow_d;
    // Edge seen on the window's last cycle still belongs to that window.
    assign edge_tot  = (slow_rise && edge_cnt != '1) ? edge_cnt + 1'b1 : edge_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_d    <= 1'b0;
            win_cnt   <= '0;
            edge_cnt  <= '0;
            clk_fault <= 1'b0;
        end else begin
            slow_d <= slow_s;
            if (!lock_s) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end else if (win_cnt == WIN_LAST) begin
                win_cnt   <= '0;
                edge_cnt  <= '0;
                clk_fault <= (edge_tot < EDGE_LO) || (edge_tot > EDGE_HI);
            end else begin
                win_cnt  <= win_cnt + 1'b1;
                edge_cnt <= edge_tot;
            end
        end
    end

    assign fault = clk_fault;
`else
    logic unused_slow_clk;
    assign unused_slow_clk = slow_clk;
    assign clk_fault       = 1'b0;
    assign fault           = 1'b0;
`endif

    assign drop = !lock_s || fault;

    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        gap_nxt   = gap_cnt;
        unique case (state)
            WAIT_LOCK: begin
                if (drop) begin
                    stab_nxt = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    state_nxt = CORE_RUN;
                    stab_nxt  = '0;
                end else begin
                    stab_nxt = stab_cnt + 1'b1;
                end
            end
            CORE_RUN: begin
                if (drop) begin
                    state_nxt = WAIT_LOCK;
                    stab_nxt  = '0;
                    gap_nxt   = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    state_nxt = ALL_RUN;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            ALL_RUN: begin
                if (drop) begin
                    state_nxt = WAIT_LOCK;
                    stab_nxt  = '0;
                    gap_nxt   = '0;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                stab_nxt  = '0;
                gap_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_LOCK;
            stab_cnt      <= '0;
            gap_cnt       <= '0;
            rst_core_n    <= 1'b0;
            rst_cpu_n     <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state      <= state_nxt;
            stab_cnt   <= stab_nxt;
            gap_cnt    <= gap_nxt;
            rst_core_n <= (state_nxt != WAIT_LOCK);
            rst_cpu_n  <= (state_nxt == ALL_RUN);
            ready      <= (state_nxt == ALL_RUN);
            if (state != WAIT_LOCK && drop && lock_loss_cnt != '1) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short timing parameters.
// Clock-monitor checks are built when PLL_RST_SEQ_CLKMON_EN is defined.
module tb_pll_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       slow_clk = 1'b0;
    logic       rst_core_n, rst_cpu_n, ready, clk_fault;
    logic [7:0] lock_loss_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned slow_half = 7;

    pll_rst_seq #(
        .LOCK_STABLE_CYC (16),
        .STAGE_GAP_CYC   (8),
        .MON_WINDOW      (100),
        .MON_EXP         (7),
        .MON_TOL         (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .slow_clk      (slow_clk),
        .rst_core_n    (rst_core_n),
        .rst_cpu_n     (rst_cpu_n),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .clk_fault     (clk_fault)
    );

    always #5 clk = ~clk;

    // slow_clk period is 2*slow_half clk cycles: 14 gives 7-8 edges per 100, 10 gives 10.
    initial begin
        forever begin
            repeat (slow_half) @(negedge clk);
            slow_clk = ~slow_clk;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_lock(input logic v);
        @(negedge clk);
        pll_locked = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_core(input int unsigned max, output int unsigned n);
        n = 0;
        while (!rst_core_n && n < max) begin
            step(1);
            n++;
        end
    endtask

    task automatic outs_all(input string tag, input logic v);
        check({tag, "_core"},  16'(rst_core_n), 16'(v));
        check({tag, "_cpu"},   16'(rst_cpu_n),  16'(v));
        check({tag, "_ready"}, 16'(ready),      16'(v));
    endtask

    initial begin
        int unsigned n;

        // Reset state
        step(2);
        outs_all("reset", 1'b0);
        check("reset_loss", 16'(lock_loss_cnt), 16'd0);
        check("reset_fault", 16'(clk_fault), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean lock: core at edge 18, cpu/ready at edge 26
        drive_lock(1'b1);
        step(1);
        step(17);
        check("lock_core_e17", 16'(rst_core_n), 16'd0);
        step(1);
        check("lock_core_e18", 16'(rst_core_n), 16'd1);
        check("lock_cpu_e18",  16'(rst_cpu_n),  16'd0);
        step(7);
        check("lock_cpu_e25",  16'(rst_cpu_n),  16'd0);
        step(1);
        check("lock_cpu_e26",   16'(rst_cpu_n), 16'd1);
        check("lock_ready_e26", 16'(ready),     16'd1);

        // Lock loss in ALL_RUN: pll_locked low at edge N
        drive_lock(1'b0);
        step(2);
        outs_all("loss_n1", 1'b1);
        step(2);
        outs_all("loss_n3", 1'b0);
        check("loss_cnt1", 16'(lock_loss_cnt), 16'd1);
        drive_lock(1'b1);
        step(1);
        step(17);
        check("relock_core_e17", 16'(rst_core_n), 16'd0);
        step(1);
        check("relock_core_e18", 16'(rst_core_n), 16'd1);
        step(8);
        check("relock_ready_e26", 16'(ready), 16'd1);

        // One-cycle glitch during WAIT_LOCK restarts the count
        do_reset();
        drive_lock(1'b1);
        repeat (10) @(posedge clk);
        drive_lock(1'b0);
        drive_lock(1'b1);
        step(1);
        step(17);
        check("glitch_core_e28", 16'(rst_core_n), 16'd0);
        step(1);
        check("glitch_core_e29", 16'(rst_core_n), 16'd1);
        check("glitch_loss", 16'(lock_loss_cnt), 16'd0);

        // Asynchronous reset mid-sequence
        do_reset();
        drive_lock(1'b1);
        step(1);
        step(20);
        check("arst_core_before", 16'(rst_core_n), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        outs_all("arst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        step(17);
        check("arst_core_e17", 16'(rst_core_n), 16'd0);
        step(1);
        check("arst_core_e18", 16'(rst_core_n), 16'd1);

        // Saturation of lock_loss_cnt
        do_reset();
        for (int unsigned i = 1; i <= 300; i++) begin
            drive_lock(1'b1);
            wait_core(40, n);
            if (n >= 40) check("sat_release_timeout", 16'(n), 16'd19);
            drive_lock(1'b0);
            step(3);
            if (i == 1)   check("sat_cnt_1",   16'(lock_loss_cnt), 16'd1);
            if (i == 255) check("sat_cnt_255", 16'(lock_loss_cnt), 16'd255);
        end
        check("sat_cnt_300", 16'(lock_loss_cnt), 16'd255);

`ifdef PLL_RST_SEQ_CLKMON_EN
        // Clock monitor: 10 edges/window faults, 7 edges/window recovers
        do_reset();
        drive_lock(1'b1);
        step(1);
        step(26);
        check("mon_ready", 16'(ready), 16'd1);
        check("mon_fault0", 16'(clk_fault), 16'd0);
        slow_half = 5;
        n = 0;
        while (!clk_fault && n < 400) begin
            step(1);
            n++;
        end
        check("mon_fault_rise", 16'(clk_fault), 16'd1);
        check("mon_cpu_same_edge", 16'(rst_cpu_n), 16'd1);
        step(1);
        outs_all("mon_drop", 1'b0);
        check("mon_loss", 16'(lock_loss_cnt), 16'd1);
        slow_half = 7;
        n = 0;
        while (clk_fault && n < 400) begin
            step(1);
            n++;
        end
        check("mon_fault_fall", 16'(clk_fault), 16'd0);
        wait_core(100, n);
        check("mon_release_lat", 16'(n), 16'd17);
        step(8);
        check("mon_ready_again", 16'(ready), 16'd1);
        check("mon_loss_hold", 16'(lock_loss_cnt), 16'd1);
`else
        check("nomon_fault", 16'(clk_fault), 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter LOCK_STABLE_CYC, default 1024: consecutive synchronized-lock cycles required before the first reset release.
REQ-002 Parameter STAGE_GAP_CYC, default 256: cycles between core release and CPU release.
REQ-003 Parameter MON_WINDOW, default 50000: clk cycles per clock-monitor window (1 ms at 50 MHz).
REQ-004 Parameter MON_EXP, default 3500: expected slow_clk rising edges per window.
REQ-005 Parameter MON_TOL, default 8: allowed ± deviation from MON_EXP.
REQ-006 clk  in  1  system clock (50 MHz PLL output); sole clock.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 pll_locked  in  1  raw PLL lock indication, asynchronous to clk.
REQ-009 slow_clk  in  1  3.5 MHz PLL output, sampled as data for monitoring.
REQ-010 rst_core_n  out  1  staged reset for video/memory logic, active-low.
REQ-011 rst_cpu_n  out  1  staged reset for CPU, active-low.
REQ-012 ready  out  1  high when both resets are released.
REQ-013 lock_loss_cnt  out  8  count of lock-loss events, saturating.
REQ-014 clk_fault  out  1  slow_clk frequency out of range.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; lock_s is the second-flop output.
REQ-016 The FSM SHALL have the states WAIT_LOCK, CORE_RUN and ALL_RUN.
REQ-017 In WAIT_LOCK, the stability counter SHALL increment while lock_s=1 and clear to 0 on any cycle with lock_s=0.
REQ-018 When the stability counter reaches LOCK_STABLE_CYC, the FSM SHALL enter CORE_RUN, and rst_core_n SHALL be 1 from that edge onward.
REQ-019 Timing reference: edge 0 is the clk edge that first samples pll_locked=1; rst_core_n SHALL rise at edge LOCK_STABLE_CYC+2.
REQ-020 In CORE_RUN, a gap counter SHALL count STAGE_GAP_CYC cycles and then the FSM SHALL enter ALL_RUN; rst_cpu_n and ready SHALL rise on the same edge.
REQ-021 Lock loss: if lock_s=0 in CORE_RUN or ALL_RUN, then on the next edge the FSM SHALL enter WAIT_LOCK, all three outputs SHALL deassert together, both counters SHALL clear, and lock_loss_cnt SHALL increment, holding at 255.
REQ-022 A lock_s=0 in WAIT_LOCK SHALL NOT increment lock_loss_cnt.
REQ-023 rst_core_n, rst_cpu_n and ready SHALL be driven directly from flops, with no combinational path from any input.
REQ-024 The outputs SHALL guarantee rst_cpu_n=1 only if rst_core_n=1, on every cycle.

Reset
REQ-025 While rst_n=0: state=WAIT_LOCK; all counters=0; synchronizer flops=0; rst_core_n=0; rst_cpu_n=0; ready=0; lock_loss_cnt=0; clk_fault=0.
REQ-026 rst_n asserted mid-sequence SHALL force the reset values immediately (asynchronously); the sequence SHALL restart from WAIT_LOCK after rst_n deasserts.
REQ-027 Deassertion of rst_n SHALL be treated as synchronous to clk; the block SHALL NOT contain an internal reset synchronizer.

Configuration
REQ-028 With PLL_RST_SEQ_CLKMON_EN defined: slow_clk SHALL be 3-flop synchronized and rising-edge detected.
REQ-029 With the macro defined: edges SHALL be counted over each MON_WINDOW cycle window, saturating at 2^16-1.
REQ-030 With the macro defined: at window end, clk_fault SHALL be registered as 1 if the count is outside [MON_EXP-MON_TOL, MON_EXP+MON_TOL], otherwise 0, and the count SHALL restart.
REQ-031 With the macro defined: clk_fault=1 in CORE_RUN or ALL_RUN SHALL be handled exactly as lock loss (REQ-021).
REQ-032 With the macro defined: while clk_fault=1, the stability counter SHALL be held at 0.
REQ-033 Monitor counters SHALL run only while lock_s=1 and SHALL clear when lock_s=0.
REQ-034 Without the macro: slow_clk SHALL be ignored, clk_fault SHALL be tied 0, and no monitor logic SHALL be present.

Structure
REQ-035 Package pll_rst_pkg SHALL hold the FSM state enum, the default parameter constants, and the 8-bit and 16-bit counter width constants.
REQ-036 Sub-module bit_sync SHALL implement an N-stage synchronizer with parameter STAGES, with asynchronous reset to 0.
REQ-037 pll_rst_seq SHALL instantiate bit_sync once for pll_locked, and once for slow_clk only when the macro is enabled.

Verification (LOCK_STABLE_CYC=16, STAGE_GAP_CYC=8, MON_WINDOW=100, MON_EXP=7, MON_TOL=1)
REQ-038 pll_locked rises at edge 0 and stays high -> rst_core_n rises at edge 18, rst_cpu_n and ready rise at edge 26.
REQ-039 pll_locked high for 10 cycles, low for 1 cycle, then high -> no release until 18 edges after the re-rise; lock_loss_cnt stays 0.
REQ-040 In ALL_RUN, pll_locked falls at edge N -> all outputs are 0 at edge N+3; lock_loss_cnt=1; the full sequence repeats on relock.
REQ-041 300 lock-loss events -> lock_loss_cnt=255.
REQ-042 rst_n pulsed low at edge 20 -> all outputs 0 with no clk edge; sequence restarts at 0.
REQ-043 With PLL_RST_SEQ_CLKMON_EN defined, slow_clk at 10 edges per window in ALL_RUN -> clk_fault=1 at the window end, then all outputs deassert; restoring 7 edges per window -> clk_fault=0 at the next window end, followed by normal re-release.
